// File: rtl/reg_bank_write_arbiter_if.sv
// Write-request bus between the register-bank requesters and the write arbiter.
// The master side is the requester group, the slave side is the arbiter.
interface reg_bank_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic [NREG-1:0]       ld_en;
  logic [WIDTH-1:0]      ld_data;
  logic                  busy;
  logic                  addr_err;

  modport master (
    output req, lock, wr_addr, wr_data,
    input  gnt, ld_en, ld_data, busy, addr_err
  );

  modport slave (
    input  req, lock, wr_addr, wr_data,
    output gnt, ld_en, ld_data, busy, addr_err
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter for the shared holding-register bank: grants one
// requester at a time and drives a single-cycle load enable into one register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no write in flight, arbitrating every cycle
// S_GRANT  | gnt pulse out, winner's address/data captured at cycle end
// S_COMMIT | ld_en (or addr_err) pulse out, arbitrating for the next write
module reg_bank_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int NREG     = 8,
  parameter int AW       = 3,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  reg_bank_write_arbiter_if.slave bus
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              BW       = $clog2(MAXBURST + 1);
  localparam logic [IW:0]     NREQ_W   = (IW + 1)'(NREQ);
  localparam logic [AW:0]     NREG_W   = (AW + 1)'(NREG);
  localparam logic [BW-1:0]   MAXB_W   = BW'(MAXBURST);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [NREG-1:0]  r_ld_en;
  logic [NREG-1:0]  w_ld_en_nxt;
  logic [WIDTH-1:0] r_ld_data;
  logic [WIDTH-1:0] w_ld_data_nxt;
  logic             r_busy;
  logic             r_addr_err;
  logic             w_addr_err_nxt;
  logic [IW-1:0]    r_rr;
  logic [IW-1:0]    r_last;
  logic [BW-1:0]    r_burst;
  logic [IW-1:0]    w_rr_idx;
  logic             w_rr_found;
  logic [IW:0]      w_probe;
  logic             w_lock_hit;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_rr_nxt;
  logic [BW-1:0]    w_burst_nxt;
  logic             w_sel;
  logic [AW-1:0]    w_addr_arr [NREQ];
  logic [WIDTH-1:0] w_data_arr [NREQ];
  logic [AW-1:0]    w_cap_addr;
  logic [WIDTH-1:0] w_cap_data;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_addr_arr[k] = bus.wr_addr[k*AW +: AW];
      w_data_arr[k] = bus.wr_data[k*WIDTH +: WIDTH];
    end
  end

  // Search from the pointer upward, wrapping; first set request wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_probe    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_probe = {1'b0, r_rr} + (IW + 1)'(k);
      if (w_probe >= NREQ_W) w_probe = w_probe - NREQ_W;
      if (!w_rr_found && bus.req[w_probe[IW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_probe[IW-1:0];
      end
    end
  end

  // r_burst == 0 only after reset, when there is no previous winner to hold.
  assign w_lock_hit  = (r_burst != '0) && (r_burst < MAXB_W) &&
                       bus.req[r_last] && bus.lock[r_last];
  assign w_win       = w_lock_hit ? r_last : w_rr_idx;
  assign w_rr_nxt    = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
  assign w_burst_nxt = w_lock_hit ? r_burst + 1'b1 : BW'(1);

  // r_last holds the requester currently in GRANT.
  assign w_cap_addr  = w_addr_arr[r_last];
  assign w_cap_data  = w_data_arr[r_last];

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = '0;
    w_ld_en_nxt    = '0;
    w_ld_data_nxt  = r_ld_data;
    w_addr_err_nxt = 1'b0;
    w_sel          = 1'b0;
    case (r_state)
      S_GRANT: begin
        w_state_nxt = S_COMMIT;
        if ({1'b0, w_cap_addr} < NREG_W) begin
          w_ld_en_nxt   = NREG'(1) << w_cap_addr;
          w_ld_data_nxt = w_cap_data;
        end else begin
          w_addr_err_nxt = 1'b1;
        end
      end
      default: begin
        // IDLE and COMMIT arbitrate identically, so COMMIT chains straight to GRANT.
        if (|bus.req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_sel       = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_ld_en    <= '0;
      r_ld_data  <= '0;
      r_busy     <= 1'b0;
      r_addr_err <= 1'b0;
      r_rr       <= '0;
      r_last     <= '0;
      r_burst    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ld_en    <= w_ld_en_nxt;
      r_ld_data  <= w_ld_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_addr_err <= w_addr_err_nxt;
      if (w_sel) begin
        r_last  <= w_win;
        r_rr    <= w_rr_nxt;
        r_burst <= w_burst_nxt;
      end
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.ld_en    = r_ld_en;
  assign bus.ld_data  = r_ld_data;
  assign bus.busy     = r_busy;
  assign bus.addr_err = r_addr_err;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed scenarios, then random traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_reg_bank_write_arbiter;
  localparam int NREQ     = 4;
  localparam int NREG     = 6;
  localparam int AW       = 3;
  localparam int WIDTH    = 8;
  localparam int MAXBURST = 4;
  localparam int IW       = $clog2(NREQ);

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  t_req  = '0;
  logic [NREQ-1:0]  t_lock = '0;
  logic [NREQ-1:0]  t_hold = '0;
  logic [AW-1:0]    t_addr [NREQ];
  logic [WIDTH-1:0] t_data [NREQ];

  int n_tests = 0;
  int n_fail  = 0;

  int m_ph, m_rr, m_last, m_burst, m_win;
  logic [NREQ-1:0]  e_gnt;
  logic [NREG-1:0]  e_ld_en;
  logic [WIDTH-1:0] e_ld_data;
  logic             e_busy;
  logic             e_err;

  always #5 clk = ~clk;

  reg_bank_write_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .WIDTH(WIDTH)) bus ();

  reg_bank_write_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .WIDTH(WIDTH), .MAXBURST(MAXBURST)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always_comb begin
    bus.req  = t_req;
    bus.lock = t_lock;
    for (int k = 0; k < NREQ; k++) begin
      bus.wr_addr[k*AW +: AW]       = t_addr[k];
      bus.wr_data[k*WIDTH +: WIDTH] = t_data[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int k = NREQ - 1; k >= 0; k--) if (bit_at(v, k)) r = k;
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rr = 0; m_last = 0; m_burst = 0; m_win = 0;
    e_gnt = '0; e_ld_en = '0; e_ld_data = '0; e_busy = 1'b0; e_err = 1'b0;
  endtask

  // Lock wins while the burst budget lasts; otherwise lowest offset from rr wins.
  task automatic model_pick();
    if (m_burst > 0 && m_burst < MAXBURST && bit_at(t_req, m_last) && bit_at(t_lock, m_last)) begin
      m_win = m_last;
      m_burst++;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (bit_at(t_req, (m_rr + k) % NREQ)) m_win = (m_rr + k) % NREQ;
      m_burst = 1;
    end
    m_last = m_win;
    m_rr   = (m_win + 1) % NREQ;
  endtask

  // m_ph: 0 nothing in flight, 1 grant issued, 2 write being committed.
  task automatic model_step();
    int ad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_gnt   = '0;
    e_ld_en = '0;
    e_err   = 1'b0;
    if (m_ph == 1) begin
      ad = int'(t_addr[IW'(m_win)]);
      if (ad < NREG) begin
        e_ld_en   = NREG'(1) << ad;
        e_ld_data = t_data[IW'(m_win)];
      end else begin
        e_err = 1'b1;
      end
      m_ph = 2;
    end else if (t_req != '0) begin
      model_pick();
      e_gnt = NREQ'(1) << m_win;
      m_ph  = 1;
    end else begin
      m_ph = 0;
    end
    e_busy = (m_ph != 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("gnt",      32'(bus.gnt),      32'(e_gnt));
    chk("ld_en",    32'(bus.ld_en),    32'(e_ld_en));
    chk("ld_data",  32'(bus.ld_data),  32'(e_ld_data));
    chk("busy",     32'(bus.busy),     32'(e_busy));
    chk("addr_err", 32'(bus.addr_err), 32'(e_err));
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    t_req  = '0;
    t_lock = '0;
    t_hold = '0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic new_req(input int i);
    t_req[IW'(i)]  = 1'b1;
    t_addr[IW'(i)] = AW'($urandom);
    t_data[IW'(i)] = WIDTH'($urandom);
  endtask

  // Requesters keep req/addr/data through the GRANT cycle, then drop or re-raise.
  task automatic rand_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (t_hold[IW'(i)]) begin
        t_hold[IW'(i)] = 1'b0;
        t_req[IW'(i)]  = 1'b0;
        t_addr[IW'(i)] = AW'($urandom);
        t_data[IW'(i)] = WIDTH'($urandom);
        if ($urandom_range(0, 2) == 0) new_req(i);
      end else if (bus.gnt[IW'(i)]) begin
        t_hold[IW'(i)] = 1'b1;
      end else if (!t_req[IW'(i)]) begin
        t_addr[IW'(i)] = AW'($urandom);
        t_data[IW'(i)] = WIDTH'($urandom);
        if ($urandom_range(0, 3) == 0) new_req(i);
      end
      t_lock[IW'(i)] = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    int n;
    int prev;
    int idx;
    int lock_seq [6];
    lock_seq = '{0, 0, 0, 0, 1, 0};

    for (int i = 0; i < NREQ; i++) begin
      t_addr[i] = '0;
      t_data[i] = '0;
    end
    model_reset();

    // reset state
    do_reset();
    chk("rst_gnt",   32'(bus.gnt),     32'h0);
    chk("rst_ld_en", 32'(bus.ld_en),   32'h0);
    chk("rst_data",  32'(bus.ld_data), 32'h0);
    chk("rst_busy",  32'(bus.busy),    32'h0);

    // single write
    t_req = 4'b0010; t_addr[1] = 3'd5; t_data[1] = 8'hA3;
    cycle();
    chk("sw_gnt",   32'(bus.gnt),  32'h2);
    chk("sw_busy1", 32'(bus.busy), 32'h1);
    cycle();
    chk("sw_ld_en",   32'(bus.ld_en),   32'h20);
    chk("sw_ld_data", 32'(bus.ld_data), 32'hA3);
    chk("sw_busy2",   32'(bus.busy),    32'h1);
    t_req = '0;
    cycle();
    chk("sw_idle",      32'(bus.busy),    32'h0);
    chk("sw_data_hold", 32'(bus.ld_data), 32'hA3);

    // fairness with all requesters continuously asking
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      t_addr[i] = AW'(i);
      t_data[i] = WIDTH'(8'h10 + i);
    end
    t_req = 4'b1111;
    n = 0; prev = 0;
    for (int c = 0; c < 14 && n < 5; c++) begin
      cycle();
      if (bus.gnt != '0) begin
        idx = onehot_idx(bus.gnt);
        chk("fair_order", 32'(idx), 32'(n % NREQ));
        if (n > 0) chk("fair_gap", 32'(c - prev), 32'd2);
        prev = c;
        n++;
      end
    end
    chk("fair_count", 32'(n), 32'd5);
    t_req = '0;
    cycle(); cycle();

    // locked burst capped at MAXBURST
    do_reset();
    t_req = 4'b0011; t_lock = 4'b0001;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      cycle();
      if (bus.gnt != '0) begin
        chk("lock_order", 32'(onehot_idx(bus.gnt)), 32'(lock_seq[n]));
        n++;
      end
    end
    chk("lock_count", 32'(n), 32'd6);
    t_req = '0; t_lock = '0;
    cycle(); cycle();

    // out-of-range address
    do_reset();
    t_req = 4'b0001; t_addr[0] = 3'd2; t_data[0] = 8'h3C;
    cycle(); cycle();
    t_req = 4'b0100; t_addr[2] = 3'd7; t_data[2] = 8'h55;
    cycle();
    chk("ae_gnt", 32'(bus.gnt), 32'h4);
    cycle();
    chk("ae_ld_en",   32'(bus.ld_en),    32'h0);
    chk("ae_err",     32'(bus.addr_err), 32'h1);
    chk("ae_ld_data", 32'(bus.ld_data),  32'h3C);
    t_req = 4'b0010; t_addr[1] = 3'd1; t_data[1] = 8'h77;
    cycle();
    chk("ae_err_pulse", 32'(bus.addr_err), 32'h0);
    chk("ae_next_gnt",  32'(bus.gnt),      32'h2);
    cycle();
    chk("ae_next_ld_en", 32'(bus.ld_en),   32'h02);
    chk("ae_next_data",  32'(bus.ld_data), 32'h77);
    t_req = '0;
    cycle();

    // reset asserted during GRANT
    do_reset();
    t_req = 4'b0100; t_addr[2] = 3'd3; t_data[2] = 8'h99;
    cycle();
    chk("rm_gnt", 32'(bus.gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rm_gnt_clr",   32'(bus.gnt),   32'h0);
    chk("rm_busy_clr",  32'(bus.busy),  32'h0);
    chk("rm_ld_en_clr", 32'(bus.ld_en), 32'h0);
    model_reset();
    t_req = '0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("rm_no_ld_en", 32'(bus.ld_en), 32'h0);
    t_req = 4'b1001;
    cycle();
    chk("rm_rr_zero", 32'(bus.gnt), 32'h1);
    cycle();
    t_req = 4'b1000;
    cycle();
    chk("rm_then_3", 32'(bus.gnt), 32'h8);
    cycle();
    t_req = '0;
    cycle();

    // random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Round-robin write arbiter and sequencer for the shared bank of D flip-flop holding registers. Up to NREQ requesters (mode FSM, button debouncers, counter update logic) each raise a write request carrying a register address and data. The block grants one requester at a time, captures its address/data and drives a one-cycle load-enable into exactly one register of the bank. It owns all write access to the bank; the registers themselves stay plain clocked flops with load enable.

## Interface
- NREQ, 4: number of requesters (2..8)
- NREG, 8: number of registers in the bank (2..16)
- AW, 3: address width, must satisfy 2^AW >= NREG
- WIDTH, 8: register data width
- MAXBURST, 4: maximum consecutive grants to one locking requester
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  per-requester write request, level, held until granted
- lock  in  NREQ  per-requester burst lock, sampled with req
- wr_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- wr_data  in  NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- ld_en  out  NREG  one-hot load enable to bank, one-cycle pulse
- ld_data  out  WIDTH  data for the enabled register
- busy  out  1  high in GRANT and COMMIT states
- addr_err  out  1  one-cycle pulse when a granted address is >= NREG

## Operation
- FSM states: IDLE, GRANT, COMMIT. All outputs registered.
- IDLE: if any req bit set, select winner, go GRANT; else stay.
- GRANT: gnt[winner]=1 for this cycle; capture wr_addr/wr_data of winner into internal regs; go COMMIT.
- COMMIT: if captured addr < NREG, ld_en[addr]=1 and ld_data=captured data; else ld_en=0, addr_err=1. Then: if any req pending (excluding the just-granted requester's same-cycle req unless lock applies), select winner and go GRANT; else IDLE.
- Requester drops req the cycle after seeing gnt; req still high then is treated as a new request.
- Round-robin: pointer rr = index after last granted requester; search rr, rr+1, ... modulo NREQ; first set req wins. Reset rr=0 (requester 0 highest priority first).
- Lock: if last winner has req and lock both high at selection and burst count < MAXBURST, it wins again regardless of rr; burst count increments. Otherwise normal round-robin, burst count reset to 1. Lone requester is always granted even past MAXBURST.
- ld_data holds last committed value between writes; ld_en is 0 except in COMMIT.
- rst low (any time): state=IDLE, gnt=0, ld_en=0, ld_data=0, busy=0, addr_err=0, rr=0, burst count=0. An in-flight write is discarded, no ld_en issued.

## Timing
- Request seen high at edge N (state IDLE) -> gnt pulse in cycle N+1 -> ld_en pulse in cycle N+2; bank register updates at edge ending cycle N+2.
- Back-to-back: one write per 2 cycles; COMMIT goes directly to GRANT, no IDLE bubble.
- gnt and ld_en are never high in the same cycle; at most one bit of each high.
- Address/data sampled only in GRANT cycle; changes afterwards have no effect.
- Reset deassertion is synchronized externally; first grant no earlier than first edge with rst high and req high.

## Test plan
- Single write: req[1]=1, wr_addr1=5, wr_data1=0xA3 in IDLE -> gnt=0010 next cycle, ld_en=0x20, ld_data=0xA3 cycle after, busy high 2 cycles.
- Fairness: req=1111 held (re-asserted after each gnt), lock=0 -> gnt order 0,1,2,3,0 at 2-cycle spacing, no gap.
- Lock burst: req=0011, lock[0]=1, MAXBURST=4 -> gnt to 0 four times, then 1, then 0 again.
- Address error: NREG=6, granted addr=7 -> ld_en=0, addr_err one pulse in COMMIT, ld_data unchanged, next request serviced normally.
- Reset mid-operation: rst low during GRANT -> gnt, ld_en, busy go 0 immediately, no ld_en after release; next req from 3 with all others idle granted in 1 cycle, rr restart at 0 verified with req=1001 -> requester 0 first.
